// File: rtl/busca_instrucao_if.sv
// Instruction-memory port between the fetch stage (master) and instruction memory (slave).
// mem_req stays high until a one-cycle mem_ack returns mem_dado.
interface busca_instrucao_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_dado;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_dado
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_dado
  );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: holds the PC, fetches one word per req/ack transaction,
// hands it downstream with valid/ready, redirects on jump/branch and watches for a dead memory port.
module busca_instrucao #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CICLOS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  busca_instrucao_if.master         mem,
  output logic [31:0]               instrucao,
  output logic [31:0]               pc_inst,
  output logic                      valida,
  input  logic                      pronto,
  input  logic                      salto,
  input  logic [25:0]               salto_addr,
  input  logic                      desvio,
  input  logic [15:0]               desvio_offset,
  input  logic [31:0]               pc_ref,
  output logic                      erro_busca
);

  localparam int CW = $clog2(TIMEOUT_CICLOS + 2);
  localparam logic [CW-1:0] LIMITE    = CW'(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] LIMITE_M1 = CW'((TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0);
  localparam logic          WATCHDOG  = (TIMEOUT_CICLOS != 0);

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    SAIDA,
    DESCARTE
  } estado_t;

  estado_t       estado;
  logic [31:0]   pc;
  logic [31:0]   alvo;
  logic [CW-1:0] contador;

  logic [31:0] pc_ref_p4;
  logic [31:0] alvo_salto;
  logic [31:0] alvo_desvio;
  logic [31:0] alvo_novo;
  logic        redireciona;

  assign mem.mem_req  = (estado == BUSCA) || (estado == DESCARTE);
  assign mem.mem_addr = pc;

  // Jump wins over branch when both arrive together; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc_ref_p4   = pc_ref + 32'd4;
    alvo_salto  = {pc_ref_p4[31:28], salto_addr, 2'b00};
    alvo_desvio = pc_ref_p4 + {{14{desvio_offset[15]}}, desvio_offset, 2'b00};
    redireciona = salto || desvio;
    alvo_novo   = salto ? alvo_salto : alvo_desvio;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      pc         <= RESET_PC;
      alvo       <= RESET_PC;
      instrucao  <= 32'h0;
      pc_inst    <= 32'h0;
      valida     <= 1'b0;
      erro_busca <= 1'b0;
      contador   <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (redireciona) pc <= alvo_novo;
          valida <= 1'b0;
          estado <= BUSCA;
        end
        BUSCA: begin
          if (mem.mem_ack) begin
            if (redireciona) begin
              pc <= alvo_novo;
            end else begin
              instrucao <= mem.mem_dado;
              pc_inst   <= pc;
              pc        <= pc + 32'd4;
              valida    <= 1'b1;
              estado    <= SAIDA;
            end
          end else if (redireciona) begin
            // The outstanding request must finish at its old address, so park the target.
            alvo   <= alvo_novo;
            estado <= DESCARTE;
          end
        end
        SAIDA: begin
          if (redireciona) begin
            pc     <= alvo_novo;
            valida <= 1'b0;
            estado <= BUSCA;
          end else if (pronto) begin
            valida <= 1'b0;
            estado <= BUSCA;
          end
        end
        DESCARTE: begin
          if (mem.mem_ack) begin
            pc     <= redireciona ? alvo_novo : alvo;
            estado <= BUSCA;
          end else if (redireciona) begin
            alvo <= alvo_novo;
          end
        end
        default: estado <= OCIOSO;
      endcase

      // Watchdog saturates at the limit; the flag is sticky until reset.
      if (mem.mem_ack) begin
        contador <= '0;
      end else if (WATCHDOG && mem.mem_req && (contador != LIMITE)) begin
        contador <= contador + CW'(1);
        if (contador == LIMITE_M1) erro_busca <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a cycle-by-cycle vector table plus hand-written
// watchdog and mid-transaction reset sequences.
module tb_busca_instrucao;

  logic        clk;
  logic        rst_n;
  logic [31:0] instrucao;
  logic [31:0] pc_inst;
  logic        valida;
  logic        pronto;
  logic        salto;
  logic [25:0] salto_addr;
  logic        desvio;
  logic [15:0] desvio_offset;
  logic [31:0] pc_ref;
  logic        erro_busca;

  int checks;
  int errors;

  busca_instrucao_if mem_if ();

  busca_instrucao #(
    .RESET_PC      (32'h0040_0000),
    .TIMEOUT_CICLOS(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mem_if),
    .instrucao    (instrucao),
    .pc_inst      (pc_inst),
    .valida       (valida),
    .pronto       (pronto),
    .salto        (salto),
    .salto_addr   (salto_addr),
    .desvio       (desvio),
    .desvio_offset(desvio_offset),
    .pc_ref       (pc_ref),
    .erro_busca   (erro_busca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] dado;
    logic        pronto;
    logic        salto;
    logic [25:0] salto_addr;
    logic        desvio;
    logic [15:0] offset;
    logic [31:0] pc_ref;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valida;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc_inst;
    logic        exp_erro;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ack, input logic [31:0] dado, input logic pr,
    input logic sa, input logic [25:0] sa_addr, input logic de, input logic [15:0] off,
    input logic [31:0] ref_pc,
    input logic e_req, input logic [31:0] e_addr, input logic e_val,
    input logic [31:0] e_instr, input logic [31:0] e_pci, input logic e_erro);
    vec_t v;
    v.ack = ack; v.dado = dado; v.pronto = pr;
    v.salto = sa; v.salto_addr = sa_addr; v.desvio = de; v.offset = off; v.pc_ref = ref_pc;
    v.exp_req = e_req; v.exp_addr = e_addr; v.exp_valida = e_val;
    v.exp_instr = e_instr; v.exp_pc_inst = e_pci; v.exp_erro = e_erro;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic setInputs(input logic ack, input logic [31:0] dado, input logic pr,
                           input logic sa, input logic [25:0] sa_addr, input logic de,
                           input logic [15:0] off, input logic [31:0] ref_pc);
    mem_if.mem_ack  = ack;
    mem_if.mem_dado = dado;
    pronto          = pr;
    salto           = sa;
    salto_addr      = sa_addr;
    desvio          = de;
    desvio_offset   = off;
    pc_ref          = ref_pc;
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v.ack, v.dado, v.pronto, v.salto, v.salto_addr, v.desvio, v.offset, v.pc_ref);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    setInputs(1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_val, input logic [31:0] e_instr,
                          input logic [31:0] e_pci, input logic e_erro);
    checkOutput({tag, " mem_req"},    {31'h0, mem_if.mem_req}, {31'h0, e_req});
    checkOutput({tag, " mem_addr"},   mem_if.mem_addr,         e_addr);
    checkOutput({tag, " valida"},     {31'h0, valida},         {31'h0, e_val});
    checkOutput({tag, " instrucao"},  instrucao,               e_instr);
    checkOutput({tag, " pc_inst"},    pc_inst,                 e_pci);
    checkOutput({tag, " erro_busca"}, {31'h0, erro_busca},     {31'h0, e_erro});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    setInputs(1'b0, 32'h0, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 32'h0);

    //             ack  dado           pr  sa  sa_addr       de  off       pc_ref          req addr           val instr          pc_inst        erro
    vecs.push_back(mk(0, 32'h0,        0, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0040_0000, 0, 32'h0,        32'h0,         0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0040_0000, 0, 32'h0,        32'h0,         0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0040_0000, 0, 32'h0,        32'h0,         0));
    vecs.push_back(mk(1, 32'h8C22_0004,0, 0, 26'h0,       0, 16'h0,    32'h0,          0, 32'h0040_0004, 1, 32'h8C22_0004,32'h0040_0000, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 32'h0,      0, 0, 26'h0,       0, 16'h0,    32'h0,          0, 32'h0040_0004, 1, 32'h8C22_0004,32'h0040_0000, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0040_0004, 0, 32'h8C22_0004,32'h0040_0000, 0));
    vecs.push_back(mk(1, 32'h0000_0001,0, 0, 26'h0,       0, 16'h0,    32'h0,          0, 32'h0040_0008, 1, 32'h0000_0001,32'h0040_0004, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 26'h0,       1, 16'hFFFC, 32'h0040_0010,  1, 32'h0040_0004, 0, 32'h0000_0001,32'h0040_0004, 0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 26'h010_0000,0, 16'h0,    32'h0040_0008,  1, 32'h0040_0004, 0, 32'h0000_0001,32'h0040_0004, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0040_0004, 0, 32'h0000_0001,32'h0040_0004, 0));
    vecs.push_back(mk(1, 32'hDEAD_BEEF,0, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0040_0000, 0, 32'h0000_0001,32'h0040_0004, 0));
    vecs.push_back(mk(1, 32'h1111_1111,0, 0, 26'h0,       0, 16'h0,    32'h0,          0, 32'h0040_0004, 1, 32'h1111_1111,32'h0040_0000, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0040_0004, 0, 32'h1111_1111,32'h0040_0000, 0));
    vecs.push_back(mk(1, 32'hBAD0_BAD0,0, 1, 26'h000_0040,1, 16'h0010, 32'h1000_0000,  1, 32'h1000_0100, 0, 32'h1111_1111,32'h0040_0000, 0));
    vecs.push_back(mk(1, 32'h2222_2222,0, 0, 26'h0,       0, 16'h0,    32'h0,          0, 32'h1000_0104, 1, 32'h2222_2222,32'h1000_0100, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 26'h0,       1, 16'h0000, 32'hFFFF_FFFC,  1, 32'h0000_0000, 0, 32'h2222_2222,32'h1000_0100, 0));
    vecs.push_back(mk(1, 32'h0BAD_F00D,0, 1, 26'h3FF_FFFF,0, 16'h0,    32'hFFFF_FFF8,  1, 32'hFFFF_FFFC, 0, 32'h2222_2222,32'h1000_0100, 0));
    vecs.push_back(mk(1, 32'h3333_3333,0, 0, 26'h0,       0, 16'h0,    32'h0,          0, 32'h0000_0000, 1, 32'h3333_3333,32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0000_0000, 0, 32'h3333_3333,32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 26'h0,       1, 16'h0001, 32'h0000_0100,  1, 32'h0000_0000, 0, 32'h3333_3333,32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 26'h000_0080,0, 16'h0,    32'h0000_0200,  1, 32'h0000_0000, 0, 32'h3333_3333,32'hFFFF_FFFC, 0));
    vecs.push_back(mk(1, 32'hCAFE_CAFE,0, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0000_0200, 0, 32'h3333_3333,32'hFFFF_FFFC, 0));
    vecs.push_back(mk(1, 32'h4444_4444,0, 0, 26'h0,       0, 16'h0,    32'h0,          0, 32'h0000_0204, 1, 32'h4444_4444,32'h0000_0200, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 26'h0,       0, 16'h0,    32'h0,          1, 32'h0000_0204, 0, 32'h4444_4444,32'h0000_0200, 0));

    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valida,
               vecs[i].exp_instr, vecs[i].exp_pc_inst, vecs[i].exp_erro);
    end

    // Watchdog: request at 0x204 left unacknowledged.
    for (int i = 1; i <= 7; i++) idleCycle();
    checkAll("wd_7", 1'b1, 32'h0000_0204, 1'b0, 32'h4444_4444, 32'h0000_0200, 1'b0);
    idleCycle();
    checkAll("wd_8", 1'b1, 32'h0000_0204, 1'b0, 32'h4444_4444, 32'h0000_0200, 1'b1);
    repeat (3) idleCycle();
    checkAll("wd_wait", 1'b1, 32'h0000_0204, 1'b0, 32'h4444_4444, 32'h0000_0200, 1'b1);
    setInputs(1'b1, 32'h5555_5555, 1'b0, 1'b0, 26'h0, 1'b0, 16'h0, 32'h0);
    @(posedge clk);
    #1;
    checkAll("wd_ack", 1'b0, 32'h0000_0208, 1'b1, 32'h5555_5555, 32'h0000_0204, 1'b1);
    setInputs(1'b0, 32'h0, 1'b1, 1'b0, 26'h0, 1'b0, 16'h0, 32'h0);
    @(posedge clk);
    #1;
    checkAll("wd_sticky", 1'b1, 32'h0000_0208, 1'b0, 32'h5555_5555, 32'h0000_0204, 1'b1);
    repeat (2) idleCycle();

    // Asynchronous reset mid-request: outputs must return to reset values without a clock edge.
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    idleCycle();
    checkAll("rst_hold", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    idleCycle();
    checkAll("rst_release", 1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
